ripple_count_monitor: RTL
=========================

// Module: ripple_count_monitor
// PURPOSE
//  Downstream consumer of the 4-bit asynchronous ripple counter (Q3..Q0 bus).
//  Synchronises the glitchy ripple outputs into the clk domain, filters transient
//  ripple codes, extends the count with a wrap counter, and presents each settled
//  value on a valid/ready output with sticky overflow on a dropped sample.
// PARAMETERS
//  CNT_W          4   width of cnt_in (ripple counter bits, Q0 = LSB)
//  WRAP_W         8   width of wrap counter (counts 2^CNT_W-1 -> lower transitions)
//  STABLE_CYCLES  2   consecutive equal synchronised samples needed to accept (>=1)
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst_n        in   1       asynchronous active-low reset
//  cnt_in       in   CNT_W   {Q3,Q2,Q1,Q0} from ripple counter, asynchronous to clk
//  clear        in   1       sync clear: wraps, overflow, pending output
//  out_ready    in   1       consumer accepts snapshot when out_valid & out_ready
//  out_valid    out  1       snapshot pending
//  out_count    out  CNT_W   settled count snapshot
//  out_wraps    out  WRAP_W  wrap count snapshot, taken together with out_count
//  wrap_pulse   out  1       one-cycle pulse on the cycle a wrap is accepted
//  overflow     out  1       sticky: an unconsumed snapshot was overwritten
// BEHAVIOUR
//  Reset (async, rst_n=0): sync regs, candidate, accepted value, stab counter, wraps,
//   all outputs = 0; filter in TRACK, output FSM in IDLE. Deassertion is synchronised
//   by the integrator.
//  Sync: cnt_in -> s1 -> s2 (two flops per bit, no logic between them).
//  Stability filter FSM, operating on s2:
//   TRACK:   if s2 != cand -> cand<=s2, stab<=0. Else stab++; when stab reaches
//            STABLE_CYCLES-1 with s2==cand -> SETTLED; accept if cand != accepted.
//   SETTLED: stay while s2==cand; on s2!=cand -> cand<=s2, stab<=0, TRACK.
//   Each settled value is accepted at most once.
//  Latency: cnt_in steady after a change -> out_valid high at the 4th posedge
//   (2 sync + STABLE_CYCLES=2). Shorter ripple transients are never accepted.
//  Accept: accepted<=cand. If cand < old accepted (unsigned), wraps<=wraps+1
//   (modulo 2^WRAP_W, silent wrap) and wrap_pulse=1 that cycle. Missed intermediate
//   codes are tolerated; at most one wrap is counted per accept.
//  Output FSM IDLE/VALID:
//   IDLE + accept -> load {out_count,out_wraps} with post-accept values, VALID.
//   VALID + out_ready & !accept -> out_valid<=0, IDLE.
//   VALID + accept & out_ready -> old snapshot consumed, new loaded, stay VALID,
//    no overflow.
//   VALID + accept & !out_ready -> snapshot overwritten, overflow<=1 (sticky).
//   Snapshot fields are stable while out_valid & !out_ready unless overwritten.
//  clear (sync, priority over accept): wraps<=0, overflow<=0, out_valid<=0, IDLE.
//   The filter and accepted value are kept, so an unchanged input is not re-reported.
//  Reset mid-handshake: asynchronous return to reset values; a pending snapshot is
//   lost with no overflow.
// STRUCTURE
//  Package ripple_mon_pkg: default CNT_W/WRAP_W/STABLE_CYCLES localparams,
//   typedef enum {TRACK, SETTLED} filt_state_t, typedef enum {IDLE, VALID} out_state_t.
//  Sub-module cnt_sync2 (parameterised-width 2-flop synchroniser, clk/rst_n).
//  Filter, wrap logic and output FSM stay in this module.
// TESTING
//  1 rst_n=0 with cnt_in=4'hA -> all outputs 0; release, hold 4'hA -> out_valid at
//    the 4th posedge, out_count=A, out_wraps=0.
//  2 Drive the full ripple counter 0..15,0 (20-cycle count period), out_ready=1
//    -> 16 snapshots in order; at 15->0 wrap_pulse=1 for one cycle; out_wraps=1.
//  3 1-cycle glitch 4'h7->4'h4->4'h8 -> only 8 is reported, 4 is never reported.
//  4 out_ready=0, accept 3 then 4 -> overflow=1, out_count=4; then ready -> valid drops.
//  5 accept and out_ready in the same cycle -> new snapshot, valid stays 1, overflow=0.
//  6 clear with out_valid=1, wraps=5 -> next cycle valid=0, wraps=0, overflow=0;
//    async rst_n mid-VALID -> immediate zeros.

Source files
------------

// File: rtl/ripple_mon_pkg.sv
// Shared defaults and state encodings for the ripple counter monitor.
package ripple_mon_pkg;

    localparam int CNT_W_DEF         = 4;
    localparam int WRAP_W_DEF        = 8;
    localparam int STABLE_CYCLES_DEF = 2;

    typedef enum logic {TRACK, SETTLED} filt_state_t;
    typedef enum logic {IDLE, VALID} out_state_t;

    // Stability counter width: must hold values up to STABLE_CYCLES.
    function automatic int stab_width(input int stable_cycles);
        return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/cnt_sync2.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
// Each bit is synchronised on its own; bus coherence is restored downstream
// by the stability filter, not here.
module cnt_sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    // Plain flop chain, nothing between the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/ripple_count_monitor.sv
// Consumer of a 4-bit asynchronous ripple counter: synchronises, filters out
// transient ripple codes, extends the count with a wrap counter and presents
// each settled value on a valid/ready output with sticky overflow.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int WRAP_W        = WRAP_W_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              clear,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic [WRAP_W-1:0] out_wraps,
    output logic              wrap_pulse,
    output logic              overflow
);

    localparam int                STAB_W    = stab_width(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0]  s2;
    logic [CNT_W-1:0]  cand;
    logic [CNT_W-1:0]  accepted;
    logic [STAB_W-1:0] stab;
    logic [STAB_W-1:0] stab_inc;
    logic [WRAP_W-1:0] wraps;

    filt_state_t filt_state, filt_next;
    out_state_t  out_state, out_next;

    logic same;
    logic settle;
    logic accept;
    logic wrap_hit;
    logic load_snap;
    logic ovf_set;

    cnt_sync2 #(.W(CNT_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cnt_in),
        .q     (s2)
    );

    assign same     = (s2 == cand);
    assign stab_inc = stab + STAB_W'(1);
    // The run is long enough once the incremented count reaches STABLE_CYCLES-1.
    assign settle   = (stab_inc >= STAB_LAST);

    // ---------------- stability filter ----------------

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) filt_state <= TRACK;
        else        filt_state <= filt_next;
    end

    // Filter next state: settle after a long enough run, re-track on any change.
    always_comb begin
        filt_next = filt_state;
        case (filt_state)
            TRACK:   if (same && settle) filt_next = SETTLED;
            SETTLED: if (!same)          filt_next = TRACK;
            default: filt_next = TRACK;
        endcase
    end

    // Filter output: accept only on the settling cycle, and only a new value.
    always_comb begin
        accept = 1'b0;
        if (filt_state == TRACK && same && settle && cand != accepted)
            accept = 1'b1;
    end

    // Candidate and run-length counter; a change always restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= '0;
            stab <= '0;
        end else if (!same) begin
            cand <= s2;
            stab <= '0;
        end else if (filt_state == TRACK && !settle) begin
            stab <= stab_inc;
        end
    end

    // ---------------- accepted value and wraps ----------------

    // A drop in value means the counter passed through its top code at least once.
    assign wrap_hit = accept && (cand < accepted);

    // Accepted value survives clear so an unchanged input is not re-reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      accepted <= '0;
        else if (accept) accepted <= cand;
    end

    // Wrap counter and its pulse; the pulse lines up with the snapshot it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wraps      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= wrap_hit && !clear;
            if (clear)         wraps <= '0;
            else if (wrap_hit) wraps <= wraps + WRAP_W'(1);
        end
    end

    // ---------------- output handshake ----------------

    // Output state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_state <= IDLE;
        else        out_state <= out_next;
    end

    // Output next state: clear wins, a new accept keeps VALID, ready drains it.
    always_comb begin
        out_next = out_state;
        if (clear) begin
            out_next = IDLE;
        end else begin
            case (out_state)
                IDLE:    if (accept) out_next = VALID;
                VALID:   if (!accept && out_ready) out_next = IDLE;
                default: out_next = IDLE;
            endcase
        end
    end

    // Output decode: snapshot load and overwrite detection.
    always_comb begin
        out_valid = (out_state == VALID);
        load_snap = accept && !clear;
        ovf_set   = (out_state == VALID) && accept && !out_ready && !clear;
    end

    // Snapshot registers carry post-accept count and wraps together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
            out_wraps <= '0;
        end else if (clear) begin
            out_count <= '0;
            out_wraps <= '0;
        end else if (load_snap) begin
            out_count <= cand;
            out_wraps <= wraps + WRAP_W'(wrap_hit);
        end
    end

    // Sticky overflow: set when a pending snapshot is overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (clear)   overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
    end

endmodule
